mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
- Multi-cycle multiply/divide unit that answers the conditional multi-cycle start strobe (MStart) raised by the condition logic.
- Runs an iterative shift-add multiply or a restoring divide over WIDTH cycles.
- Holds the pipeline through a combinational Busy, pulses Done for one cycle, and keeps both result words until the next accepted start.

Parameters:
WIDTH, 32, operand and result word width (>=2)

Ports:
CLK  input  1  clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request strobe, driven from the condition unit's MStart (already gated by CondEx)
MCycleOp  input  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  product low word / quotient
Result2  output  WIDTH  product high word / remainder
Busy  output  1  stall request to the pipeline
Done  output  1  one-cycle completion pulse
DivByZero  output  1  registered; set when the last accepted division had Operand2==0

Behaviour:
- Clock and reset: one clock CLK; Reset is asynchronous, active-high. Reset forces state IDLE and clears Result1, Result2, DivByZero and all internal registers to 0. It overrides any operation in flight, including a reset asserted mid-COMPUTE; no Done is produced for the aborted operation.
- States: IDLE, COMPUTE, DONE.
- Accepting a request:
  - An edge with state in {IDLE, DONE} and Start=1 is accepted.
  - On acceptance the unit latches Operand1, Operand2 and MCycleOp, clears the iteration counter and enters COMPUTE.
  - Start is ignored while in COMPUTE.
- Busy is combinational: (Start & state!=COMPUTE) | (state==COMPUTE). It therefore rises in the same cycle as Start.
- Iteration and latency:
  - COMPUTE performs one iteration per edge, for exactly WIDTH edges. The counter is ceil(log2(WIDTH+1)) bits.
  - The WIDTH-th iteration edge loads Result1/Result2 (after sign fix-up) and enters DONE.
  - If Start is high in cycle 0, Busy is high in cycles 0..WIDTH and Done is high in cycle WIDTH+1 only. Busy is 0 in DONE.
- DONE: lasts one cycle and returns to IDLE, or goes back to COMPUTE if Start=1 (back-to-back operation). Results hold until the next completion or reset.
- Multiply:
  - Unsigned: 2*WIDTH product; Result1 = low word, Result2 = high word.
  - Signed: iterate on the operand magnitudes, then negate the 2*WIDTH product when the operand signs differ. The most-negative operand has magnitude 2^(WIDTH-1) and is handled unsigned.
- Divide:
  - Restoring, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Most-negative / -1: quotient = most-negative, remainder = 0, no flag.
- Divide by zero: Result1 = all ones, Result2 = Operand1 (unchanged, for both signed and unsigned), DivByZero=1. The operation still takes the full WIDTH cycles.
- DivByZero updates only at a division completion (cleared by a non-zero division). Multiplies leave it unchanged.
- Operand changes after the acceptance edge have no effect on the result.

Test Plan:
- Unsigned mul, 0xFFFFFFFF * 0x00000002, Start one cycle -> Busy high cycles 0..32, Done high in cycle 33 only, Result2=0x00000001, Result1=0xFFFFFFFE.
- Signed mul, -3 (0xFFFFFFFD) * 7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB; and 0x80000000 * 0x80000000 -> Result2=0x40000000, Result1=0.
- Signed div, -7 / 2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1); and 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0, DivByZero=0.
- Unsigned div by zero, 100 / 0 -> Result1=0xFFFFFFFF, Result2=100, DivByZero=1. A following 100/7 -> Result1=14, Result2=2, DivByZero=0.
- Start held high throughout plus back-to-back: second request accepted in the DONE cycle of the first, Busy then stays high. Operands changed mid-COMPUTE -> results reflect the latched values. Start pulses during COMPUTE -> ignored, no extra Done.
- Reset asserted asynchronously at iteration 10 of a multiply -> Busy, Done, Result1, Result2, DivByZero all 0 immediately. A new Start after release -> correct result at the full latency.

Source files
------------

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: iterative shift-add multiply and
// restoring divide, one bit per clock over WIDTH clocks.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t           state;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [CW-1:0]    cnt;

   logic             in_sgn;
   logic [WIDTH-1:0] in_m1;
   logic [WIDTH-1:0] in_m2;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] ma;
   logic [WIDTH-1:0] mb;

   // magnitudes of the incoming operands seed the low register at accept
   assign in_sgn = MCycleOp[0];
   assign in_m1  = (in_sgn & Operand1[WIDTH-1]) ? -Operand1 : Operand1;
   assign in_m2  = (in_sgn & Operand2[WIDTH-1]) ? -Operand2 : Operand2;

   assign neg_a = op[0] & a[WIDTH-1];
   assign neg_b = op[0] & b[WIDTH-1];
   assign ma    = neg_a ? -a : a;
   assign mb    = neg_b ? -b : b;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;

   assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
   assign mul_hi = sum[WIDTH:1];
   assign mul_lo = {sum[0], lo[WIDTH-1:1]};

   // remainder stays below the divisor, so the difference fits WIDTH bits
   logic [WIDTH:0]   sh;
   logic             ge;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;

   assign sh     = {hi, lo[WIDTH-1]};
   assign ge     = sh >= {1'b0, mb};
   assign diff   = sh[WIDTH-1:0] - mb;
   assign div_hi = ge ? diff : sh[WIDTH-1:0];
   assign div_lo = {lo[WIDTH-2:0], ge};

   logic [WIDTH-1:0]   nxt_hi;
   logic [WIDTH-1:0]   nxt_lo;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_f;
   logic [WIDTH-1:0]   quo_f;
   logic [WIDTH-1:0]   rem_f;
   logic               flip;
   logic               dbz_now;

   assign nxt_hi  = op[1] ? div_hi : mul_hi;
   assign nxt_lo  = op[1] ? div_lo : mul_lo;
   assign flip    = neg_a ^ neg_b;
   assign prod    = {nxt_hi, nxt_lo};
   assign prod_f  = flip ? -prod : prod;
   assign quo_f   = flip ? -nxt_lo : nxt_lo;
   assign rem_f   = neg_a ? -nxt_hi : nxt_hi;
   assign dbz_now = (b == '0);

   assign Busy = Start | (state == COMPUTE);
   assign Done = (state == DONE);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         op        <= '0;
         a         <= '0;
         b         <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         Result1   <= '0;
         Result2   <= '0;
         DivByZero <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (Start) begin
                  op    <= MCycleOp;
                  a     <= Operand1;
                  b     <= Operand2;
                  hi    <= '0;
                  lo    <= MCycleOp[1] ? in_m1 : in_m2;
                  cnt   <= '0;
                  state <= COMPUTE;
               end else begin
                  state <= IDLE;
               end
            end
            COMPUTE: begin
               hi  <= nxt_hi;
               lo  <= nxt_lo;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= DONE;
                  if (!op[1]) begin
                     {Result2, Result1} <= prod_f;
                  end else if (dbz_now) begin
                     Result1   <= '1;
                     Result2   <= a;
                     DivByZero <= 1'b1;
                  end else begin
                     Result1   <= quo_f;
                     Result2   <= rem_f;
                     DivByZero <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_unit.sv
// Randomized bench for mcycle_unit against a cycle-count/arithmetic
// reference model, plus directed literal cases.
module tb_mcycle_unit;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [1:0]   MCycleOp = '0;
   logic [W-1:0] Operand1 = '0;
   logic [W-1:0] Operand2 = '0;
   logic [W-1:0] Result1;
   logic [W-1:0] Result2;
   logic         Busy;
   logic         Done;
   logic         DivByZero;

   mcycle_unit #(.WIDTH(W)) dut (
      .CLK(CLK),
      .Reset(Reset),
      .Start(Start),
      .MCycleOp(MCycleOp),
      .Operand1(Operand1),
      .Operand2(Operand2),
      .Result1(Result1),
      .Result2(Result2),
      .Busy(Busy),
      .Done(Done),
      .DivByZero(DivByZero)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 0;

   int           m_left = 0;
   bit           m_done = 0;
   logic [W-1:0] m_r1 = '0, m_r2 = '0, p_r1 = '0, p_r2 = '0;
   logic         m_dz = 0, p_dz = 0, p_div = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // arithmetic reference from the operation definitions
   function automatic void model(input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r1, output logic [W-1:0] r2,
                                 output logic dz, output logic is_div);
      logic [63:0] p;
      longint      sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 0;
      is_div = op[1];
      r1 = '0;
      r2 = '0;
      case (op)
         2'd0: begin
            p = {32'b0, a} * {32'b0, b};
            r1 = p[31:0]; r2 = p[63:32];
         end
         2'd1: begin
            p = sa * sb;
            r1 = p[31:0]; r2 = p[63:32];
         end
         default: begin
            if (b == 0) begin
               r1 = '1; r2 = a; dz = 1;
            end else if (op == 2'd2) begin
               r1 = a / b; r2 = a % b;
            end else begin
               p = sa / sb; r1 = p[31:0];
               p = sa % sb; r2 = p[31:0];
            end
         end
      endcase
   endfunction

   always @(posedge CLK) begin
      if (Reset) begin
         m_left = 0; m_done = 0; m_r1 = '0; m_r2 = '0; m_dz = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_r1 = p_r1; m_r2 = p_r2;
            if (p_div) m_dz = p_dz;
            m_done = 1;
         end
      end else begin
         m_done = 0;
         if (Start) begin
            model(MCycleOp, Operand1, Operand2, p_r1, p_r2, p_dz, p_div);
            m_left = W;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("busy", Busy, Start | (m_left > 0));
         check("done", Done, m_done);
         check("result1", Result1, m_r1);
         check("result2", Result2, m_r2);
         check("divbyzero", DivByZero, m_dz);
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat);
      @(posedge CLK); #1;
      MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1;
      @(posedge CLK); #1;
      Start = 0;
      Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
      lat = 1;
      while (!Done && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("done_seen", Done, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom % 8)
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         4: return W'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      logic [W-1:0] t1, t2;
      logic td, tv;

      model(2'd1, 32'hFFFF_FFFD, 32'd7, t1, t2, td, tv);
      check("model_smul_r1", t1, 32'hFFFF_FFEB);
      check("model_smul_r2", t2, 32'hFFFF_FFFF);
      model(2'd3, 32'hFFFF_FFF9, 32'd2, t1, t2, td, tv);
      check("model_sdiv_q", t1, 32'hFFFF_FFFD);
      check("model_sdiv_r", t2, 32'hFFFF_FFFF);
      model(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, t1, t2, td, tv);
      check("model_ovf_q", t1, 32'h8000_0000);
      check("model_ovf_r", t2, 32'h0);

      @(negedge CLK);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_r1", Result1, 0);
      check("rst_r2", Result2, 0);
      check("rst_dz", DivByZero, 0);
      @(posedge CLK); #1;
      Reset = 0;
      chk_en = 1;

      run_op(2'd0, 32'hFFFF_FFFF, 32'd2, lat);
      check("umul_lat", lat, 33);
      check("umul_r1", Result1, 32'hFFFF_FFFE);
      check("umul_r2", Result2, 32'h1);
      @(posedge CLK); #1;
      check("done_one_cycle", Done, 0);

      run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat);
      check("smul_r1", Result1, 32'hFFFF_FFEB);
      check("smul_r2", Result2, 32'hFFFF_FFFF);
      run_op(2'd1, 32'h8000_0000, 32'h8000_0000, lat);
      check("smul_min_r1", Result1, 32'h0);
      check("smul_min_r2", Result2, 32'h4000_0000);

      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat);
      check("sdiv_q", Result1, 32'hFFFF_FFFD);
      check("sdiv_r", Result2, 32'hFFFF_FFFF);
      run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      check("sdiv_ovf_q", Result1, 32'h8000_0000);
      check("sdiv_ovf_r", Result2, 32'h0);
      check("sdiv_ovf_dz", DivByZero, 0);

      run_op(2'd2, 32'd100, 32'd0, lat);
      check("udiv0_lat", lat, 33);
      check("udiv0_q", Result1, 32'hFFFF_FFFF);
      check("udiv0_r", Result2, 32'd100);
      check("udiv0_dz", DivByZero, 1);
      run_op(2'd2, 32'd100, 32'd7, lat);
      check("udiv_q", Result1, 32'd14);
      check("udiv_r", Result2, 32'd2);
      check("udiv_dz", DivByZero, 0);

      run_op(2'd3, 32'hFFFF_FFF9, 32'd0, lat);
      check("sdiv0_r", Result2, 32'hFFFF_FFF9);
      run_op(2'd0, 32'd3, 32'd5, lat);
      check("mul_keeps_dz", DivByZero, 1);
      check("mul_small", Result1, 32'd15);

      // back-to-back: hold Start, re-accept in the DONE cycle
      @(posedge CLK); #1;
      MCycleOp = 2'd2; Operand1 = 32'd1000; Operand2 = 32'd3; Start = 1;
      lat = 0;
      do begin
         @(posedge CLK); #1;
         lat++;
         Operand1 = $urandom; Operand2 = $urandom;
      end while (!Done && lat < 100);
      check("b2b_first_lat", lat, 33);
      check("b2b_q", Result1, 32'd333);
      check("b2b_busy_in_done", Busy, 1);
      MCycleOp = 2'd1; Operand1 = 32'hFFFF_FFFB; Operand2 = 32'd6;
      @(posedge CLK); #1;
      Start = 0;
      check("b2b_busy_compute", Busy, 1);
      lat = 1;
      while (!Done && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("b2b_second_lat", lat, 33);
      check("b2b_r1", Result1, 32'hFFFF_FFE2);
      check("b2b_r2", Result2, 32'hFFFF_FFFF);

      run_op(2'd2, 32'd9, 32'd0, lat);
      // asynchronous reset in the middle of a multiply
      @(posedge CLK); #1;
      MCycleOp = 2'd0; Operand1 = 32'h0001_2345; Operand2 = 32'h777; Start = 1;
      @(posedge CLK); #1;
      Start = 0;
      repeat (9) @(posedge CLK);
      #3;
      Reset = 1;
      m_left = 0; m_done = 0; m_r1 = '0; m_r2 = '0; m_dz = 0;
      #1;
      check("arst_busy", Busy, 0);
      check("arst_done", Done, 0);
      check("arst_r1", Result1, 0);
      check("arst_r2", Result2, 0);
      check("arst_dz", DivByZero, 0);
      @(posedge CLK); #1;
      Reset = 0;
      run_op(2'd1, 32'hFFFF_CFC7, 32'd678, lat);
      check("post_rst_lat", lat, 33);
      check("post_rst_r1", Result1, 32'hFF80_490A);
      check("post_rst_r2", Result2, 32'hFFFF_FFFF);

      for (int i = 0; i < 3000; i++) begin
         @(posedge CLK); #1;
         Start = ((i % 1000) < 200) ? 1'b1 : (($urandom % 4) == 0);
         MCycleOp = 2'($urandom);
         Operand1 = pick();
         Operand2 = pick();
      end
      Start = 0;
      repeat (40) @(posedge CLK);
      #1;
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
